// File: rtl/mibench_caller.sv
// mibench_caller: issues a batch of indexed calls to a pipelined component,
// limits the number of outstanding calls, and sums the returned data.
// Optional watchdog: define MIBENCH_CALLER_TIMEOUT_EN to end a stuck batch
// after TIMEOUT_CYCLES cycles without any call or return accept.
module mibench_caller #(
    parameter int MAX_INFLIGHT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        host_start,
    input  logic [15:0] host_count,
    input  logic [31:0] host_base_idx,
    output logic        host_busy,
    output logic        host_done,
    output logic [31:0] host_sum,
    output logic        host_error,
    output logic        call_valid,
    input  logic        call_stall,
    output logic [31:0] call_idx,
    input  logic        ret_valid,
    output logic        ret_stall,
    input  logic [31:0] ret_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [7:0] MAX_INF = 8'(MAX_INFLIGHT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [15:0] count_nxt;
    logic [15:0] issued;
    logic [15:0] issued_nxt;
    logic [7:0]  inflight;
    logic [7:0]  inflight_nxt;
    logic        call_acc;
    logic        ret_acc;
    logic        start_acc;
    logic        timeout;

    assign call_acc  = call_valid & ~call_stall;
    assign ret_acc   = ret_valid & ~ret_stall;
    assign start_acc = (state == IDLE) & host_start;

`ifdef MIBENCH_CALLER_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd_cnt;
    logic        wd_active;

    assign wd_active = (state == RUN) || (state == DRAIN);
    assign timeout   = wd_active && !call_acc && !ret_acc && (wd_cnt == WD_LAST);

    // Watchdog counts consecutive RUN/DRAIN cycles in which nothing was accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (!wd_active || call_acc || ret_acc) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    // Error flag is cleared by a new batch and set when the watchdog fires
    always_ff @(posedge clock) begin
        if (reset) begin
            host_error <= 1'b0;
        end else if (start_acc) begin
            host_error <= 1'b0;
        end else if (timeout) begin
            host_error <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign host_error         = 1'b0;
`endif

    // Next-state, issue counter and outstanding-call bookkeeping
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        issued_nxt   = issued;
        inflight_nxt = inflight;

        if (call_acc) begin
            issued_nxt = issued + 16'd1;
        end

        if (call_acc && !ret_acc) begin
            inflight_nxt = inflight + 8'd1;
        end else if (ret_acc && !call_acc && (inflight != 8'd0)) begin
            inflight_nxt = inflight - 8'd1;
        end

        case (state)
            IDLE: begin
                if (host_start) begin
                    count_nxt    = host_count;
                    issued_nxt   = '0;
                    inflight_nxt = '0;
                    state_nxt    = (host_count == 16'd0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (timeout) begin
                    state_nxt = FINISH;
                end else if (call_acc && (issued == count - 16'd1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (timeout) begin
                    state_nxt = FINISH;
                end else if (ret_acc && (inflight == 8'd1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and all host/call outputs, registered from next-state values
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            issued     <= '0;
            inflight   <= '0;
            call_idx   <= '0;
            host_sum   <= '0;
            call_valid <= 1'b0;
            host_busy  <= 1'b0;
            host_done  <= 1'b0;
            ret_stall  <= 1'b1;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            issued     <= issued_nxt;
            inflight   <= inflight_nxt;
            call_valid <= (state_nxt == RUN) && (issued_nxt < count_nxt) &&
                          (inflight_nxt < MAX_INF);
            host_busy  <= (state_nxt != IDLE);
            host_done  <= (state_nxt == FINISH);
            ret_stall  <= !((state_nxt == RUN) || (state_nxt == DRAIN));
            if (start_acc) begin
                call_idx <= host_base_idx;
                host_sum <= '0;
            end else begin
                if (call_acc) begin
                    call_idx <= call_idx + 32'd1;
                end
                if (ret_acc) begin
                    host_sum <= host_sum + ret_data;
                end
            end
        end
    end

endmodule
